// File: rtl/key_event_queue.sv
// key_event_queue
//   Turns the raw keycode level coming from the NIOS PIO into discrete key
//   events. A fresh press produces one event. While 'hold' is set, a held key
//   also produces auto-repeat events. Events are buffered in a small FIFO,
//   and the consumer pops them with a valid/ready handshake.
//
// Ports
//   Clk        system clock
//   Reset_n    synchronous reset, active low
//   keycode    raw keycode level, asynchronous to game logic (0 = no key)
//   hold       1 = auto-repeat enabled
//   flush      synchronous queue flush
//   ev_ready   consumer accepts the head event
//   ev_valid   queue non-empty
//   ev_key     head event keycode (0 when empty)
//   ev_repeat  head event is an auto-repeat (0 when empty or fresh press)
//   count      queue occupancy, 0..DEPTH
//   overflow   sticky: an event was dropped because the queue was full
//   key_level  keycode after one register stage

module key_event_queue #(
  parameter int unsigned KEY_W        = 8,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned REPEAT_DELAY = 15_000_000,
  parameter int unsigned REPEAT_RATE  = 5_000_000
) (
  input  logic                       Clk,
  input  logic                       Reset_n,
  input  logic [KEY_W-1:0]           keycode,
  input  logic                       hold,
  input  logic                       flush,
  input  logic                       ev_ready,
  output logic                       ev_valid,
  output logic [KEY_W-1:0]           ev_key,
  output logic                       ev_repeat,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic [KEY_W-1:0]           key_level
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned REP_W   = $clog2(REP_MAX + 1);

  logic [KEY_W-1:0] kc_q;
  logic [KEY_W-1:0] kc_p;
  logic [REP_W-1:0] rep_cnt;
  // 0 while the next repeat is the first one after a press, so the longer
  // REPEAT_DELAY applies; 1 once the key is in steady repeat.
  logic             rep_started;

  logic [KEY_W:0]   mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic             key_active;
  logic             press_ev;
  logic             repeat_ev;
  logic [REP_W-1:0] rep_target;
  logic             push_req;
  logic [KEY_W:0]   push_data;
  logic             full;
  logic             do_pop;
  logic             do_push;
  logic             drop;

  // A press requires the key to differ from the previous sample, so a
  // repeat can never coincide with a press.
  always_comb begin
    key_active = (kc_q != '0);
    press_ev   = key_active && (kc_q != kc_p);
    rep_target = rep_started ? REP_W'(REPEAT_RATE - 1) : REP_W'(REPEAT_DELAY - 1);
    repeat_ev  = hold && key_active && !press_ev && (rep_cnt == rep_target);
    push_req   = press_ev || repeat_ev;
    push_data  = {repeat_ev, kc_q};
  end

  // A pop frees a slot on the same edge, so a full queue can still accept
  // an event when the consumer pops in that cycle.
  always_comb begin
    ev_valid = (count != '0);
    full     = (count == CNT_W'(DEPTH));
    do_pop   = ev_valid && ev_ready;
    do_push  = push_req && (!full || do_pop);
    drop     = push_req && full && !do_pop;
  end

  always_comb begin
    ev_key    = '0;
    ev_repeat = 1'b0;
    if (ev_valid) begin
      ev_key    = mem[rd_ptr][KEY_W-1:0];
      ev_repeat = mem[rd_ptr][KEY_W];
    end
  end

  assign key_level = kc_q;

  // The sample stages keep running through a flush, so a key that is still
  // held does not look like a new press afterwards. The flush also restarts
  // the full repeat delay.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      kc_q        <= '0;
      kc_p        <= '0;
      rep_cnt     <= '0;
      rep_started <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overflow    <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      kc_q <= keycode;
      kc_p <= kc_q;
      if (flush) begin
        rep_cnt     <= '0;
        rep_started <= 1'b0;
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        count       <= '0;
        overflow    <= 1'b0;
      end else begin
        if (press_ev || !hold || !key_active) begin
          rep_cnt     <= '0;
          rep_started <= 1'b0;
        end else if (repeat_ev) begin
          rep_cnt     <= '0;
          rep_started <= 1'b1;
        end else begin
          rep_cnt <= rep_cnt + 1'b1;
        end

        if (do_push) begin
          mem[wr_ptr] <= push_data;
          wr_ptr      <= wr_ptr + 1'b1;
        end
        if (do_pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        if (drop) begin
          overflow <= 1'b1;
        end

        case ({do_push, do_pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

endmodule
